// File: rtl/int_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_request_ctrl
// Brief    : Interrupt request initiator for the instruction converter; latches
//            and arbitrates sources, holds intReq until intAck, tracks service
//            until rfi, and gates trap instructions via trapReq.
//            Optional build macro: INT_EDGE_EN (rising-edge triggered sources).
// Revision : 1.0 - initial release
// ============================================================================
module int_request_ctrl #(
    parameter int NUM_SRC  = 4,
    parameter int ID_WIDTH = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  irq_in,
    input  logic [NUM_SRC-1:0]  irq_mask,
    input  logic                msr_ee,
    input  logic                trap_en,
    input  logic                intAck,
    input  logic [PC_WIDTH-1:0] cur_pc,
    input  logic                rfi,
    output logic                intReq,
    output logic                trapReq,
    output logic [ID_WIDTH-1:0] int_id,
    output logic [PC_WIDTH-1:0] srr0,
    output logic                in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_WIDTH-1:0] r_sel_id;
    logic [ID_WIDTH-1:0] w_sel_id_nxt;
    logic                r_int_req;
    logic                w_int_req_nxt;
    logic                r_trap_req;
    logic                w_trap_req_nxt;
    logic [ID_WIDTH-1:0] r_int_id;
    logic [ID_WIDTH-1:0] w_int_id_nxt;
    logic [PC_WIDTH-1:0] r_srr0;
    logic [PC_WIDTH-1:0] w_srr0_nxt;
    logic                r_in_service;
    logic                w_in_service_nxt;

    logic [NUM_SRC-1:0]  w_pending;
    logic [NUM_SRC-1:0]  w_eligible;
    logic [ID_WIDTH-1:0] w_winner;
    logic                w_ack_take;

    // ------------------------------------------------------------------
    // Pending source capture
    // ------------------------------------------------------------------
`ifdef INT_EDGE_EN
    logic [NUM_SRC-1:0] r_irq_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic [NUM_SRC-1:0] w_ack_clr;

    // A new rising edge on the acked source in the same cycle must survive.
    always_comb begin
        w_ack_clr     = w_ack_take ? (NUM_SRC'(1) << r_sel_id) : '0;
        w_pending_nxt = (r_pending & ~w_ack_clr) | (irq_in & ~r_irq_prev);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
        end else begin
            r_irq_prev <= irq_in;
            r_pending  <= w_pending_nxt;
        end
    end

    assign w_pending = r_pending;
`else
    assign w_pending = irq_in;
`endif

    assign w_eligible = w_pending & irq_mask;
    assign w_ack_take = (r_state == ST_REQ) && intAck;

    // Fixed priority: lowest index wins.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = ID_WIDTH'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Request / service state machine
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_sel_id_nxt     = r_sel_id;
        w_int_req_nxt    = r_int_req;
        w_int_id_nxt     = r_int_id;
        w_srr0_nxt       = r_srr0;
        w_in_service_nxt = r_in_service;
        w_trap_req_nxt   = trap_en && !r_in_service;

        case (r_state)
            ST_IDLE: begin
                if ((|w_eligible) && msr_ee) begin
                    w_state_nxt   = ST_REQ;
                    w_sel_id_nxt  = w_winner;
                    w_int_req_nxt = 1'b1;
                end
            end
            ST_REQ: begin
                // intAck takes precedence: INTR is already in the pipeline.
                if (intAck) begin
                    w_state_nxt      = ST_SERVICE;
                    w_srr0_nxt       = cur_pc;
                    w_int_id_nxt     = r_sel_id;
                    w_in_service_nxt = 1'b1;
                    w_int_req_nxt    = 1'b0;
                end else if (!msr_ee || !w_eligible[r_sel_id]) begin
                    w_state_nxt   = ST_IDLE;
                    w_int_req_nxt = 1'b0;
                end
            end
            ST_SERVICE: begin
                w_int_req_nxt = 1'b0;
                if (rfi) begin
                    w_state_nxt      = ST_IDLE;
                    w_in_service_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_int_req_nxt    = 1'b0;
                w_in_service_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sel_id     <= '0;
            r_int_req    <= 1'b0;
            r_trap_req   <= 1'b0;
            r_int_id     <= '0;
            r_srr0       <= '0;
            r_in_service <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel_id     <= w_sel_id_nxt;
            r_int_req    <= w_int_req_nxt;
            r_trap_req   <= w_trap_req_nxt;
            r_int_id     <= w_int_id_nxt;
            r_srr0       <= w_srr0_nxt;
            r_in_service <= w_in_service_nxt;
        end
    end

    assign intReq     = r_int_req;
    assign trapReq    = r_trap_req;
    assign int_id     = r_int_id;
    assign srr0       = r_srr0;
    assign in_service = r_in_service;

endmodule
`default_nettype wire
